// File: rtl/four_bit_1_2_demux.sv
// rtl/four_bit_1_2_demux.sv - 4-bit 1:2 demux feeding two independent 2-entry channel FIFOs
// Target channel comes from s, or from an alternating pointer when auto=1.

module four_bit_1_2_demux_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop_ready,
    output logic [3:0] head_data,
    output logic       valid,
    output logic [1:0] cnt
);
    logic [3:0] head_q, head_d;
    logic [3:0] tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;

    assign valid     = (cnt_q != 2'd0);
    assign pop       = valid & pop_ready;
    assign head_data = valid ? head_q : 4'b0000;
    assign cnt       = cnt_q;

    // The parent only pushes when cnt < 2, so push+pop together implies cnt == 1.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: head_d = push_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= 4'b0000;
            tail_q <= 4'b0000;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module four_bit_1_2_demux #(
    parameter logic TDM_START = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       s,
    input  logic       auto,
    output logic [3:0] a_data,
    output logic [3:0] b_data,
    output logic       a_valid,
    output logic       b_valid,
    input  logic       a_ready,
    input  logic       b_ready,
    output logic [1:0] a_cnt,
    output logic [1:0] b_cnt,
    output logic       tdm_ptr
);
    logic ptr_q, ptr_d;
    logic target;
    logic accept;
    logic push_a, push_b;

    assign target = auto ? ptr_q : s;
    // Registered counts only: a full channel stays blocked even if it pops this cycle.
    assign in_ready = target ? (b_cnt != 2'd2) : (a_cnt != 2'd2);
    assign accept   = in_valid & in_ready;
    assign push_a   = accept & ~target;
    assign push_b   = accept &  target;
    assign tdm_ptr  = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (accept && auto) ptr_d = ~ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= TDM_START;
        else        ptr_q <= ptr_d;
    end

    four_bit_1_2_demux_fifo u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop_ready (a_ready),
        .head_data (a_data),
        .valid     (a_valid),
        .cnt       (a_cnt)
    );

    four_bit_1_2_demux_fifo u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop_ready (b_ready),
        .head_data (b_data),
        .valid     (b_valid),
        .cnt       (b_cnt)
    );
endmodule

// File: tb/tb_four_bit_1_2_demux.sv
// tb/tb_four_bit_1_2_demux.sv - directed self-checking bench for four_bit_1_2_demux
module tb_four_bit_1_2_demux;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       s = 1'b0;
    logic       auto_sel = 1'b0;
    logic [3:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready = 1'b0;
    logic       b_ready = 1'b0;
    logic [1:0] a_cnt, b_cnt;
    logic       tdm_ptr;

    int errors = 0;
    int checks = 0;

    four_bit_1_2_demux dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .auto(auto_sel), .a_data(a_data), .b_data(b_data), .a_valid(a_valid), .b_valid(b_valid),
        .a_ready(a_ready), .b_ready(b_ready), .a_cnt(a_cnt), .b_cnt(b_cnt), .tdm_ptr(tdm_ptr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; s = 1'b0; auto_sel = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (a_cnt !== 2'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got a=%0d b=%0d expected 0 0", a_cnt, b_cnt); end
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got a=%b b=%b expected 0 0", a_valid, b_valid); end
        checks++; if (a_data !== 4'h0 || b_data !== 4'h0) begin errors++; $display("FAIL reset_data: got a=%h b=%h expected 0 0", a_data, b_data); end
        checks++; if (tdm_ptr !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_ptr_ready: got ptr=%b rdy=%b expected 0 1", tdm_ptr, in_ready); end
        do_reset();
    endtask

    task automatic test_fill_drain();
        do_reset();
        in_valid = 1'b1; in_data = 4'h5; tick();
        in_data = 4'hA; tick();
        in_valid = 1'b0; #1;
        checks++; if (a_cnt !== 2'd2 || a_data !== 4'h5) begin errors++; $display("FAIL fill_a: got cnt=%0d data=%h expected 2 5", a_cnt, a_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_s0: got %b expected 0", in_ready); end
        s = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_s1: got %b expected 1", in_ready); end
        s = 1'b0; a_ready = 1'b1; tick();
        checks++; if (a_data !== 4'hA || a_cnt !== 2'd1) begin errors++; $display("FAIL drain1: got data=%h cnt=%0d expected a 1", a_data, a_cnt); end
        tick();
        checks++; if (a_valid !== 1'b0 || a_data !== 4'h0 || a_cnt !== 2'd0) begin errors++; $display("FAIL drain2: got v=%b data=%h cnt=%0d expected 0 0 0", a_valid, a_data, a_cnt); end
    endtask

    task automatic test_tdm();
        logic [3:0] got;
        do_reset();
        auto_sel = 1'b1; a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 4'(k + 1);
            tick();
            got = (k % 2 == 0) ? a_data : b_data;
            checks++; if (got !== 4'(k + 1)) begin errors++; $display("FAIL tdm_word%0d: got %h expected %h", k, got, 4'(k + 1)); end
        end
        in_valid = 1'b0;
        checks++; if (tdm_ptr !== 1'b0) begin errors++; $display("FAIL tdm_ptr_end: got %b expected 0", tdm_ptr); end
        tick();
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL tdm_empty: got a=%b b=%b expected 0 0", a_valid, b_valid); end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        in_valid = 1'b1; in_data = 4'h7; tick();
        checks++; if (a_cnt !== 2'd1 || a_data !== 4'h7) begin errors++; $display("FAIL sim_setup: got cnt=%0d data=%h expected 1 7", a_cnt, a_data); end
        in_data = 4'h9; a_ready = 1'b1; tick();
        checks++; if (a_cnt !== 2'd1 || a_data !== 4'h9) begin errors++; $display("FAIL sim_push_pop: got cnt=%0d data=%h expected 1 9", a_cnt, a_data); end
        in_valid = 1'b0; tick();
        checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL sim_drain: got cnt=%0d expected 0", a_cnt); end
    endtask

    task automatic test_full_pop();
        do_reset();
        in_valid = 1'b1; in_data = 4'h1; tick();
        in_data = 4'h2; tick();
        in_data = 4'h3; a_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (a_cnt !== 2'd1 || a_data !== 4'h2) begin errors++; $display("FAIL full_pop_edge: got cnt=%0d data=%h expected 1 2", a_cnt, a_data); end
        a_ready = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_retry_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (a_cnt !== 2'd2 || b_cnt !== 2'd0) begin errors++; $display("FAIL full_pop_accept: got a=%0d b=%0d expected 2 0", a_cnt, b_cnt); end
        a_ready = 1'b1; tick();
        checks++; if (a_data !== 4'h3) begin errors++; $display("FAIL full_pop_order: got %h expected 3", a_data); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        auto_sel = 1'b1; in_valid = 1'b1;
        in_data = 4'h5; tick();
        in_data = 4'h6; tick();
        in_data = 4'h7; tick();
        in_valid = 1'b0; in_data = 4'hC;
        checks++; if (a_cnt !== 2'd2 || b_cnt !== 2'd1 || tdm_ptr !== 1'b1) begin errors++; $display("FAIL ar_setup: got a=%0d b=%0d ptr=%b expected 2 1 1", a_cnt, b_cnt, tdm_ptr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_cnt !== 2'd0 || b_cnt !== 2'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL ar_async_cnt: got a=%0d b=%0d expected 0 0", a_cnt, b_cnt); end
        checks++; if (a_data !== 4'h0 || b_data !== 4'h0 || tdm_ptr !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_async_out: got a=%h b=%h ptr=%b rdy=%b expected 0 0 0 1", a_data, b_data, tdm_ptr, in_ready); end
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (a_cnt !== 2'd1 || a_data !== 4'hC || b_cnt !== 2'd0) begin errors++; $display("FAIL ar_first_accept: got a=%0d ad=%h b=%0d expected 1 c 0", a_cnt, a_data, b_cnt); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        auto_sel = 1'b1; a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
        in_data = 4'h1; tick();
        checks++; if (tdm_ptr !== 1'b1 || a_data !== 4'h1) begin errors++; $display("FAIL ms_first: got ptr=%b a=%h expected 1 1", tdm_ptr, a_data); end
        auto_sel = 1'b0; s = 1'b0; in_data = 4'h2; tick();
        checks++; if (a_data !== 4'h2 || b_valid !== 1'b0) begin errors++; $display("FAIL ms_manual1: got a=%h bv=%b expected 2 0", a_data, b_valid); end
        in_data = 4'h3; tick();
        checks++; if (a_data !== 4'h3 || tdm_ptr !== 1'b1) begin errors++; $display("FAIL ms_manual2: got a=%h ptr=%b expected 3 1", a_data, tdm_ptr); end
        auto_sel = 1'b1; in_data = 4'h4; tick();
        in_valid = 1'b0;
        checks++; if (b_data !== 4'h4 || a_valid !== 1'b0 || tdm_ptr !== 1'b0) begin errors++; $display("FAIL ms_back_auto: got b=%h av=%b ptr=%b expected 4 0 0", b_data, a_valid, tdm_ptr); end
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        a_ready = 1'b1; b_ready = 1'b1; auto_sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 4'(k * 5 + 3); s = k[0];
            tick();
        end
        checks++; if (a_cnt !== 2'd0 || b_cnt !== 2'd0 || tdm_ptr !== 1'b0) begin errors++; $display("FAIL idle: got a=%0d b=%0d ptr=%b expected 0 0 0", a_cnt, b_cnt, tdm_ptr); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_tdm();
        test_simul_push_pop();
        test_full_pop();
        test_async_reset();
        test_mode_switch();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/four_bit_1_2_demux.md
FOUR_BIT_1_2_DEMUX -- requirements
Module: four_bit_1_2_demux

Interface
REQ-001 Parameter: TDM_START, default 1'b0, channel pointer value after reset (0 = channel A, 1 = channel B).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  4  nibble to be routed.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 s  input  1  channel select when auto=0 (0 = A, 1 = B).
REQ-008 auto  input  1  1 = alternate channels per accepted word, s ignored.
REQ-009 a_data / b_data  output  4  head entry of channel A / B buffer.
REQ-010 a_valid / b_valid  output  1  channel A / B buffer non-empty.
REQ-011 a_ready / b_ready  input  1  downstream consumes head of A / B.
REQ-012 a_cnt / b_cnt  output  2  occupancy of A / B buffer (0..2).
REQ-013 tdm_ptr  output  1  current auto-mode channel pointer.

Function
REQ-014 Each channel SHALL have an independent 2-entry FIFO; order preserved per channel.
REQ-015 Target channel SHALL be tdm_ptr when auto=1, else s.
REQ-016 in_ready SHALL be 1 iff target channel count < 2, computed from registered counts only (no pass-through of same-cycle pop).
REQ-017 Accept = in_valid & in_ready; accepted nibble SHALL be written to target FIFO tail on that clock edge.
REQ-018 Accepted word SHALL appear on x_data with x_valid=1 no earlier than the next cycle (1-cycle latency when FIFO was empty).
REQ-019 Pop = x_valid & x_ready; head SHALL advance on that edge, second entry (if any) becomes head next cycle.
REQ-020 Simultaneous push and pop on same channel with count 1 SHALL leave count 1 with new head = pushed word.
REQ-021 Full channel (count 2) SHALL deassert in_ready for words targeting it even if popped that cycle; the other channel is unaffected.
REQ-022 x_valid SHALL equal (x_cnt != 0); x_data SHALL be 4'b0000 when x_valid=0.
REQ-023 tdm_ptr SHALL toggle on each accept while auto=1; SHALL hold when auto=0 or no accept.
REQ-024 Switching auto mid-stream SHALL take effect for the same-cycle target; tdm_ptr value retained across mode changes.
REQ-025 x_ready asserted while x_valid=0 SHALL have no effect; counts never underflow or exceed 2.
REQ-026 in_valid=0 SHALL never modify state regardless of in_data/s.

Reset
REQ-027 rst_n=0 SHALL immediately force a_cnt=b_cnt=0, a_valid=b_valid=0, a_data=b_data=0, tdm_ptr=TDM_START, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; no word accepted before reset is output after release.
REQ-029 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 auto=0, s=0, send 4'h5 then 4'hA, a_ready=0 -> a_cnt=2, in_ready=0 for s=0, in_ready=1 for s=1; then a_ready=1 -> a_data 5 then A.
REQ-031 auto=1, TDM_START=0, send 1,2,3,4 with both ready=1 -> A receives 1,3; B receives 2,4; tdm_ptr ends 0.
REQ-032 A count=1 (head 7), push 4'h9 to A and a_ready=1 same cycle -> next cycle a_cnt=1, a_data=9.
REQ-033 A full, a_ready=1, in_valid=1 targeting A -> word not accepted that cycle, accepted next cycle.
REQ-034 Both channels holding data, pulse rst_n low mid-cycle -> outputs zero asynchronously, tdm_ptr=TDM_START, no stale data after release.
REQ-035 auto=1 ptr=1, switch auto=0 with s=0 for 2 words, return auto=1 -> next auto word goes to B.
